// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl
// Sequencer for an in-place radix-2 Cooley-Tukey NTT. It walks LOG_N stages
// of N/2 butterflies each. For every butterfly it issues a read address pair,
// a twiddle ROM index and the butterfly mode. The same address pair returns
// as the write-back pair once it has passed through a BF_LAT-deep delay line.
// A stall freezes the counters and the delay line and masks rd_en/wr_en for
// that cycle.
//
// Optional build macro: NTT_CYCLE_CNT_EN. When it is defined the block gets a
// 32-bit cycle_cnt output. That counter measures RUN+DRAIN cycles of the last
// transform, stalls included.
module ntt_stage_ctrl #(
    parameter int LOG_N  = 8,
    parameter int BF_LAT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       inverse,
    input  logic                       stall,
    output logic                       rd_en,
    output logic [LOG_N-1:0]           rd_addr0,
    output logic [LOG_N-1:0]           rd_addr1,
    output logic [LOG_N-2:0]           tw_addr,
    output logic                       bf_sel,
    output logic                       wr_en,
    output logic [LOG_N-1:0]           wr_addr0,
    output logic [LOG_N-1:0]           wr_addr1,
    output logic [$clog2(LOG_N+1)-1:0] stage,
    output logic                       busy,
    output logic                       done
`ifdef NTT_CYCLE_CNT_EN
    ,
    output logic [31:0]                cycle_cnt
`endif
);

    // Widths: butterfly counter, stage counter, drain counter, wide address
    // scratch (one spare bit so the shift left never loses the top bit),
    // twiddle index.
    localparam int BW = LOG_N - 1;
    localparam int SW = $clog2(LOG_N + 1);
    localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam int AW = LOG_N + 1;
    localparam int TW = LOG_N - 1;

    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG_N - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(BF_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // One write-back delay line entry.
    typedef struct packed {
        logic             v;
        logic [LOG_N-1:0] a0;
        logic [LOG_N-1:0] a1;
    } wb_t;

    // ------------------------------------------------------------------
    // Address arithmetic for stage s, butterfly b:
    //   j = b mod 2^s, g = b / 2^s
    //   top    = g * 2^(s+1) + j   (insert a zero at bit s of b)
    //   bottom = top + 2^s
    //   twiddle= j << (LOG_N-1-s)
    // ------------------------------------------------------------------
    function automatic logic [AW-1:0] low_mask(input logic [SW-1:0] s);
        return (AW'(1) << s) - AW'(1);
    endfunction

    function automatic logic [LOG_N-1:0] top_addr(input logic [SW-1:0] s,
                                                  input logic [BW-1:0] b);
        logic [AW-1:0] bx;
        bx = AW'(b);
        return LOG_N'(((bx & ~low_mask(s)) << 1) | (bx & low_mask(s)));
    endfunction

    function automatic logic [LOG_N-1:0] bot_addr(input logic [SW-1:0] s,
                                                  input logic [BW-1:0] b);
        return LOG_N'(AW'(top_addr(s, b)) + (AW'(1) << s));
    endfunction

    function automatic logic [TW-1:0] twiddle(input logic [SW-1:0] s,
                                              input logic [BW-1:0] b);
        return TW'((AW'(b) & low_mask(s)) << (LAST_STAGE - s));
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [BW-1:0]    b_q;
    logic [SW-1:0]    stage_q;
    logic [DW-1:0]    drain_q;
    logic             run_q;
    logic             busy_q;
    logic             done_q;
    logic             inv_q;
    logic [LOG_N-1:0] rd_a0_q;
    logic [LOG_N-1:0] rd_a1_q;
    logic [TW-1:0]    tw_q;
`ifdef NTT_CYCLE_CNT_EN
    logic [31:0]      cnt_q;
`endif

    // Which butterfly gets presented next when the address registers load.
    logic [SW-1:0]    load_stage;
    logic [BW-1:0]    load_b;
    logic [LOG_N-1:0] rd_a0_d;
    logic [LOG_N-1:0] rd_a1_d;
    logic [TW-1:0]    tw_d;

    // The butterfly to present next: the first one of a transform, the first
    // one of the next stage, or the next one of the current stage.
    always_comb begin
        load_stage = stage_q;
        load_b     = b_q + BW'(1);
        if (state_q == S_IDLE) begin
            load_stage = '0;
            load_b     = '0;
        end else if (state_q == S_DRAIN) begin
            load_stage = stage_q + SW'(1);
            load_b     = '0;
        end
        rd_a0_d = top_addr(load_stage, load_b);
        rd_a1_d = bot_addr(load_stage, load_b);
        tw_d    = twiddle(load_stage, load_b);
    end

    // Main FSM: counters, registered status outputs and the read address
    // registers. The address registers load only when a new butterfly
    // becomes current, so they hold through stalls and DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            stage_q <= '0;
            drain_q <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            inv_q   <= 1'b0;
            rd_a0_q <= '0;
            rd_a1_q <= '0;
            tw_q    <= '0;
`ifdef NTT_CYCLE_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        b_q     <= '0;
                        stage_q <= '0;
                        drain_q <= '0;
                        run_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        inv_q   <= inverse;
                        rd_a0_q <= rd_a0_d;
                        rd_a1_q <= rd_a1_d;
                        tw_q    <= tw_d;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (&b_q) begin
                            // Last butterfly of the stage has just issued.
                            state_q <= S_DRAIN;
                            run_q   <= 1'b0;
                            drain_q <= '0;
                        end else begin
                            b_q     <= b_q + BW'(1);
                            rd_a0_q <= rd_a0_d;
                            rd_a1_q <= rd_a1_d;
                            tw_q    <= tw_d;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        if (drain_q == LAST_DRAIN) begin
                            if (stage_q == LAST_STAGE) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_RUN;
                                stage_q <= stage_q + SW'(1);
                                b_q     <= '0;
                                run_q   <= 1'b1;
                                rd_a0_q <= rd_a0_d;
                                rd_a1_q <= rd_a1_d;
                                tw_q    <= tw_d;
                            end
                        end else begin
                            drain_q <= drain_q + DW'(1);
                        end
                    end
                end
                S_DONE: begin
                    // Done pulse lasts exactly one cycle and ignores stall.
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
`ifdef NTT_CYCLE_CNT_EN
            if (state_q == S_IDLE && start) begin
                cnt_q <= '0;
            end else if (busy_q) begin
                cnt_q <= cnt_q + 32'd1;
            end
`endif
        end
    end

    // A butterfly issues only when the sequencer is in RUN and nothing
    // downstream is frozen.
    assign rd_en    = run_q & ~stall;
    assign rd_addr0 = rd_a0_q;
    assign rd_addr1 = rd_a1_q;
    assign tw_addr  = tw_q;
    assign bf_sel   = inv_q;
    assign stage    = stage_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef NTT_CYCLE_CNT_EN
    assign cycle_cnt = cnt_q;
`endif

    // ------------------------------------------------------------------
    // Write-back delay line. It advances only on non-stalled cycles, so a
    // write-back pair appears exactly BF_LAT advancing cycles after its read.
    // ------------------------------------------------------------------
    wb_t dl_q [BF_LAT];
    wb_t dl_d [BF_LAT];

    assign dl_d[0] = '{v: rd_en, a0: rd_addr0, a1: rd_addr1};

    for (genvar gi = 1; gi < BF_LAT; gi++) begin : g_dl
        assign dl_d[gi] = dl_q[gi-1];
    end

    // Shift the delay line on every non-stalled cycle; reset empties it so an
    // aborted transform leaves no pending write-backs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BF_LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else if (!stall) begin
            for (int i = 0; i < BF_LAT; i++) begin
                dl_q[i] <= dl_d[i];
            end
        end
    end

    assign wr_en    = dl_q[BF_LAT-1].v & ~stall;
    assign wr_addr0 = dl_q[BF_LAT-1].a0;
    assign wr_addr1 = dl_q[BF_LAT-1].a1;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// tb_ntt_stage_ctrl
// Bench for ntt_stage_ctrl with LOG_N=3, BF_LAT=2. A transaction-level model
// counts the non-stalled cycles since start and derives stage, butterfly,
// drain, write-back and done position from that count arithmetically. Directed
// transforms are also compared against hand-written address tables and
// latencies. Optional build macro: NTT_CYCLE_CNT_EN.
module tb_ntt_stage_ctrl;

    localparam int LOG_N  = 3;
    localparam int BF_LAT = 2;
    localparam int HALF   = (1 << LOG_N) / 2;
    localparam int PER    = HALF + BF_LAT;
    localparam int TOTAL  = LOG_N * PER;
    localparam int SW     = $clog2(LOG_N + 1);

    logic clk = 1'b0;
    logic reset, start, inverse, stall;
    logic rd_en, wr_en, bf_sel, busy, done;
    logic [LOG_N-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic [LOG_N-2:0] tw_addr;
    logic [SW-1:0]    stage;
`ifdef NTT_CYCLE_CNT_EN
    logic [31:0]      cycle_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_stage_ctrl #(.LOG_N(LOG_N), .BF_LAT(BF_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .inverse  (inverse),
        .stall    (stall),
        .rd_en    (rd_en),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .tw_addr  (tw_addr),
        .bf_sel   (bf_sel),
        .wr_en    (wr_en),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1),
        .stage    (stage),
        .busy     (busy),
        .done     (done)
`ifdef NTT_CYCLE_CNT_EN
        ,
        .cycle_cnt(cycle_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model and per-cycle compare
    // ------------------------------------------------------------------
    bit mon_en = 0, active = 0, zero_next = 0, inv_m = 0;
    int k = 0, cc = 0;
    bit hist_v [TOTAL];
    int hist_a0 [TOTAL];
    int hist_a1 [TOTAL];
    bit e_rd, e_wr, e_busy, e_done;
    int m_s, m_b, m_m, m_j, m_g, ea0, ea1, etw;

    bit capture = 0, done_seen = 0;
    int first_rd = -1, done_cyc = -1;
    int cap_a0[$], cap_a1[$], cap_tw[$];

    always @(negedge clk) begin
        if (mon_en) begin
            e_rd = 0; e_wr = 0; e_busy = 0; e_done = 0;
            m_s = 0; ea0 = 0; ea1 = 0; etw = 0;
            if (zero_next) begin
                chk("rst_rd_addr0", rd_addr0, 0);
                chk("rst_rd_addr1", rd_addr1, 0);
                chk("rst_tw_addr", tw_addr, 0);
                chk("rst_wr_addr0", wr_addr0, 0);
                chk("rst_wr_addr1", wr_addr1, 0);
                chk("rst_stage", stage, 0);
                chk("rst_bf_sel", bf_sel, 0);
                zero_next = 0;
            end
            if (active) begin
                if (k == TOTAL) begin
                    e_done = 1;
                end else begin
                    e_busy = 1;
                    m_s = k / PER;
                    m_b = k % PER;
                    if (!stall && m_b < HALF) begin
                        e_rd = 1;
                        m_m = 1 << m_s;
                        m_j = m_b & (m_m - 1);
                        m_g = m_b >> m_s;
                        ea0 = (m_g << (m_s + 1)) | m_j;
                        ea1 = ea0 + m_m;
                        etw = m_j << (LOG_N - 1 - m_s);
                        hist_v[k] = 1; hist_a0[k] = ea0; hist_a1[k] = ea1;
                    end else if (!stall) begin
                        hist_v[k] = 0;
                    end
                    if (!stall && k >= BF_LAT && hist_v[k-BF_LAT]) e_wr = 1;
                end
            end
            chk("rd_en", rd_en, e_rd);
            chk("wr_en", wr_en, e_wr);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            if (e_busy) chk("stage", stage, m_s);
            if (e_rd) begin
                chk("rd_addr0", rd_addr0, ea0);
                chk("rd_addr1", rd_addr1, ea1);
                chk("tw_addr", tw_addr, etw);
                chk("bf_sel", bf_sel, inv_m);
            end
            if (e_wr) begin
                chk("wr_addr0", wr_addr0, hist_a0[k-BF_LAT]);
                chk("wr_addr1", wr_addr1, hist_a1[k-BF_LAT]);
            end
`ifdef NTT_CYCLE_CNT_EN
            chk("cycle_cnt", cycle_cnt, cc);
`endif
            // Observation for the directed tables and latencies.
            if (capture && rd_en === 1'b1) begin
                if (first_rd < 0) first_rd = cyc;
                cap_a0.push_back(int'(rd_addr0));
                cap_a1.push_back(int'(rd_addr1));
                cap_tw.push_back(int'(tw_addr));
            end
            if (done === 1'b1) begin
                done_seen = 1;
                if (capture && done_cyc < 0) done_cyc = cyc;
            end
            // Advance the model to the next cycle.
            if (reset) begin
                active = 0; zero_next = 1; cc = 0;
            end else if (active) begin
                if (k == TOTAL) begin
                    active = 0;
                end else begin
                    cc++;
                    if (!stall) k++;
                end
            end else if (start) begin
                active = 1; k = 0; cc = 0; inv_m = inverse;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed transform with hand-written expectations
    // ------------------------------------------------------------------
    int lit_a0 [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_a1 [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    task automatic run_directed(input bit inv, input int stall_at, input int exp_lat,
                                input bit repulse, input string tag);
        int c;
        int n;
        cap_a0.delete(); cap_a1.delete(); cap_tw.delete();
        first_rd = -1; done_cyc = -1; done_seen = 0; capture = 1;
        inverse = inv; start = 1; tick; start = 0; inverse = ~inv;
        c = 1;
        while (!done_seen && c < 100) begin
            stall = (stall_at > 0 && c >= stall_at && c < stall_at + 3);
            start = repulse && (c == 3);
            tick;
            c++;
        end
        stall = 0; start = 0;
        tick;
        capture = 0;
        chk({tag, "_done_seen"}, done_seen, 1);
        chk({tag, "_latency"}, done_cyc - first_rd, exp_lat);
        chk({tag, "_rd_count"}, cap_a0.size(), 12);
        n = (cap_a0.size() < 12) ? cap_a0.size() : 12;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_tab_a0"}, cap_a0[i], lit_a0[i]);
            chk({tag, "_tab_a1"}, cap_a1[i], lit_a1[i]);
            chk({tag, "_tab_tw"}, cap_tw[i], lit_tw[i]);
        end
        $display("txn %s inv=%0d reads=%0d latency=%0d", tag, inv, cap_a0.size(), done_cyc - first_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        reset = 1; start = 0; stall = 0; inverse = 0;
        tick; tick;
        mon_en = 1;
        tick;
        reset = 0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_en", rd_en, 0);
        tick; tick;

        // Plain forward transform.
        run_directed(0, 0, 18, 0, "plain");
        // Three stall cycles at stage 1, butterfly 2 (cycle 9 after start).
        run_directed(0, 9, 21, 0, "stall");
`ifdef NTT_CYCLE_CNT_EN
        chk("stall_cycle_cnt", cycle_cnt, 21);
`endif
        // Inverse transform with a start re-pulse while running.
        run_directed(1, 0, 18, 1, "inverse");

        // Reset during stage 1 DRAIN (cycle 11 after start).
        inverse = 0; start = 1; tick; start = 0;
        repeat (10) tick;
        reset = 1; tick; reset = 0;
        chk("abort_busy", busy, 0);
        chk("abort_stage", stage, 0);
        done_seen = 0;
        repeat (12) tick;
        chk("abort_no_done", done_seen, 0);
        $display("txn abort done_seen=%0d", done_seen);
        run_directed(0, 0, 18, 0, "after_abort");

        // Randomized transforms with random stalls and stray starts.
        for (int t = 0; t < 10; t++) begin
            repeat ($urandom_range(0, 3)) begin
                stall = 1'($urandom_range(0, 1));
                tick;
            end
            done_seen = 0;
            stall = 1'($urandom_range(0, 1));
            inverse = 1'($urandom_range(0, 1));
            start = 1; tick; start = 0;
            c = 0;
            while (!done_seen && c < 300) begin
                stall = ($urandom_range(0, 3) == 0);
                start = ($urandom_range(0, 7) == 0);
                inverse = 1'($urandom_range(0, 1));
                tick;
                c++;
            end
            stall = 0; start = 0;
            chk("rand_done_seen", done_seen, 1);
            $display("txn random %0d cycles=%0d", t, c);
            tick;
        end

        repeat (3) tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
